nrzi_rx_decoder: RTL
====================

// Module: nrzi_rx_decoder
// PURPOSE
//  Receive end of the team's inversion-based serial line code (NRZI, USB convention).
//  Recovers data bits from line transitions: no transition = 1, transition = 0.
//  Removes stuffed zeros, hunts for a SYNC byte, then deserialises LSB-first words.
//  Words are delivered over a valid/ready handshake. Sits between the line sampler and the lab's word-level consumer.
// PARAMETERS
//  WIDTH      8      deserialised word width, bits
//  STUFF_LEN  6      consecutive decoded 1s after which one 0 is stuffed
//  SYNC       8'h80  WIDTH-bit sync word, compared LSB-first (line order 0,0,0,0,0,0,0,1)
// PORTS
//  clk        in   1      rising-edge clock; single clock domain
//  rst_n      in   1      synchronous reset, active low
//  en         in   1      frame active; low forces IDLE
//  bit_en     in   1      strobe: line_in holds a valid line bit this cycle
//  line_in    in   1      NRZI line sample
//  out_data   out  WIDTH  received word, LSB = first bit received
//  out_valid  out  1      out_data holds an undelivered word
//  out_ready  in   1      consumer accepts the word when out_valid && out_ready
//  stuff_err  out  1      one-cycle pulse: bit-stuffing violation
//  ovf_err    out  1      one-cycle pulse: word completed while the holding register was full and not drained
//  busy       out  1      1 in HUNT or RECV
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, prev_line=1, ones_cnt=0, bit_cnt=0, shift=0.
//   Outputs after reset: out_data=0, out_valid=0, stuff_err=0, ovf_err=0, busy=0.
//   Reset mid-frame discards a pending word.
//  Decode, on a cycle with en && bit_en:
//   d = ~(line_in ^ prev_line); prev_line <= line_in.
//   Cycles with bit_en=0 change nothing except the handshake.
//  Unstuffing:
//   ones_cnt increments on d=1 and clears on d=0; saturates at STUFF_LEN.
//   When ones_cnt==STUFF_LEN, the next d is the stuff bit:
//    d=0: bit dropped (not shifted, not counted); ones_cnt<=0.
//    d=1: stuff_err pulses the next cycle; state<=ERROR.
//   Unstuffing is active in both HUNT and RECV.
//  FSM (2-bit state):
//   IDLE -> HUNT when en=1.
//   HUNT: shift<={d,shift[WIDTH-1:1]} for each unstuffed bit.
//    When the updated shift==SYNC: go to RECV, bit_cnt<=0.
//   RECV: shift in unstuffed bits, bit_cnt++.
//    On the WIDTH-th bit: word=updated shift, bit_cnt<=0, stay in RECV.
//   ERROR: ignores bit_en; leaves only via en=0 (-> IDLE).
//   Any state -> IDLE on the clock where en=0.
//    Clears ones_cnt, bit_cnt, shift; prev_line<=1.
//    out_valid and out_data are kept, so a pending word is still deliverable.
//  Output/handshake:
//   Word completes at edge N; out_valid=1 and out_data=word are visible after edge N (1 clock latency from the final bit_en).
//   A transfer occurs on an edge where out_valid && out_ready; out_valid clears unless a new word completes at the same edge.
//   Completion at the same edge as a transfer: new word loaded, out_valid stays 1, no ovf_err.
//   Completion while out_valid && !out_ready: new word dropped, old out_data kept, ovf_err pulses 1 cycle.
//  busy = (state==HUNT || state==RECV); registered.
// TESTING
//  1. Reset, en=1; send SYNC then 0xA5 NRZI-encoded, bit_en every cycle, out_ready=1.
//     -> out_valid=1 for one cycle, out_data=8'hA5, 1 clk after the 8th data bit.
//  2. SYNC then 0xFF, with a stuffed 0 inserted after 6 ones.
//     -> out_data=8'hFF; 9 line bits consumed; stuff_err=0.
//  3. SYNC then seven consecutive decoded 1s.
//     -> stuff_err pulse on the 7th bit; state=ERROR; busy=0; further bits ignored until en=0.
//  4. out_ready=0; send SYNC, 0x12, 0x34.
//     -> out_data stays 8'h12, ovf_err pulses once at 0x34 completion.
//     -> Raise out_ready: exactly one transfer of 8'h12.
//  5. Drop en mid-word (4 bits of 0x3C), re-raise en, send SYNC, 0x3C.
//     -> Partial word discarded; out_data=8'h3C after the second sync.
//  6. Assert rst_n=0 for 1 clk with out_valid=1 pending.
//     -> All outputs 0 next cycle; state IDLE.

Source files
------------

// File: rtl/nrzi_rx_decoder.sv
// NRZI line receiver: transition decode, zero unstuffing, SYNC hunt
// and LSB-first deserialisation onto a valid/ready word port.
module nrzi_rx_decoder #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      STUFF_LEN = 6,
  parameter logic [WIDTH-1:0] SYNC      = 8'h80
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             bit_en,
  input  logic             line_in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             stuff_err,
  output logic             ovf_err,
  output logic             busy
);

  localparam int unsigned OW = $clog2(STUFF_LEN + 1);
  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [OW-1:0] STUFF_MAX = OW'(STUFF_LEN);
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HUNT  = 2'd1,
    RECV  = 2'd2,
    ERROR = 2'd3
  } state_t;

  state_t state, state_nx;
  logic   busy_nx;

  logic             prev_line;
  logic [OW-1:0]    ones_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shift;

  logic             d;
  logic [WIDTH-1:0] sh;
  logic             take;
  logic             at_stuff;
  logic             viol;
  logic             drop;
  logic             shift_en;
  logic             sync_hit;
  logic             word_done;

  always_comb begin
    d         = ~(line_in ^ prev_line);
    sh        = {d, shift[WIDTH-1:1]};
    take      = en && bit_en &&
                (state == HUNT || state == RECV);
    at_stuff  = (ones_cnt == STUFF_MAX);
    viol      = take && at_stuff && d;
    drop      = take && at_stuff && !d;
    shift_en  = take && !at_stuff;
    sync_hit  = shift_en && (state == HUNT) &&
                (sh == SYNC);
    word_done = shift_en && (state == RECV) &&
                (bit_cnt == LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= busy_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (!en) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: state_nx = HUNT;
        HUNT: begin
          if (viol)
            state_nx = ERROR;
          else if (sync_hit)
            state_nx = RECV;
        end
        RECV: begin
          if (viol)
            state_nx = ERROR;
        end
        default: state_nx = state;
      endcase
    end
  end

  always_comb begin
    busy_nx = (state_nx == HUNT) ||
              (state_nx == RECV);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_line <= 1'b1;
      ones_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      stuff_err <= 1'b0;
      ovf_err   <= 1'b0;
    end else begin
      stuff_err <= viol;
      ovf_err   <= 1'b0;
      if (!en) begin
        prev_line <= 1'b1;
        ones_cnt  <= '0;
        bit_cnt   <= '0;
        shift     <= '0;
      end else if (take) begin
        prev_line <= line_in;
        if (drop) begin
          ones_cnt <= '0;
        end else if (shift_en) begin
          ones_cnt <= d ? ones_cnt + 1'b1 : '0;
          shift    <= sh;
          if (sync_hit)
            bit_cnt <= '0;
          else if (state == RECV)
            bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
        end
      end
      // a word landing on a full, undrained register is lost
      if (word_done) begin
        if (!out_valid || out_ready) begin
          out_data  <= sh;
          out_valid <= 1'b1;
        end else begin
          ovf_err <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
